// File: rtl/pc_flags_unit_pkg.sv
// Shared encodings for the PC/flags execution block: condition codes, PC source select, flag bit positions.
package pc_flags_unit_pkg;

    localparam int NUM_FLAGS = 5;

    // Flag vector layout is {C,L,F,Z,N}, MSB first.
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [3:0] {
        COND_EQ    = 4'b0000,
        COND_NE    = 4'b0001,
        COND_CS    = 4'b0010,
        COND_CC    = 4'b0011,
        COND_HI    = 4'b0100,
        COND_LS    = 4'b0101,
        COND_GT    = 4'b0110,
        COND_LE    = 4'b0111,
        COND_FS    = 4'b1000,
        COND_FC    = 4'b1001,
        COND_LO    = 4'b1010,
        COND_HS    = 4'b1011,
        COND_LT    = 4'b1100,
        COND_GE    = 4'b1101,
        COND_UC    = 4'b1110,
        COND_NEVER = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_ABS  = 2'b01,
        PC_REL  = 2'b10,
        PC_HOLD = 2'b11
    } pc_src_e;

endpackage

// File: rtl/pc_flags_unit_cond_eval.sv
// Purpose: evaluate a 4-bit Bcond/Jcond field against a {C,L,F,Z,N} flag vector.
// Latency: purely combinational.
// Backpressure: none; output is valid whenever inputs are.
module pc_flags_unit_cond_eval
    import pc_flags_unit_pkg::*;
(
    input  logic [NUM_FLAGS-1:0] flags,
    input  logic [3:0]           cond,
    output logic                 cond_met
);

    logic flag_c, flag_l, flag_f, flag_z, flag_n;

    always_comb begin
        flag_c   = flags[FLAG_C];
        flag_l   = flags[FLAG_L];
        flag_f   = flags[FLAG_F];
        flag_z   = flags[FLAG_Z];
        flag_n   = flags[FLAG_N];
        cond_met = 1'b0;
        case (cond_e'(cond))
            COND_EQ:    cond_met = flag_z;
            COND_NE:    cond_met = !flag_z;
            COND_CS:    cond_met = flag_c;
            COND_CC:    cond_met = !flag_c;
            COND_HI:    cond_met = flag_l;
            COND_LS:    cond_met = !flag_l;
            COND_GT:    cond_met = flag_n;
            COND_LE:    cond_met = !flag_n;
            COND_FS:    cond_met = flag_f;
            COND_FC:    cond_met = !flag_f;
            COND_LO:    cond_met = !flag_l && !flag_z;
            COND_HS:    cond_met = flag_l || flag_z;
            COND_LT:    cond_met = !flag_n && !flag_z;
            COND_GE:    cond_met = flag_n || flag_z;
            COND_UC:    cond_met = 1'b1;
            COND_NEVER: cond_met = 1'b0;
            default:    cond_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flags_unit.sv
// Purpose: program counter and status flags register, with branch condition evaluation.
// Latency: pc and flags update one cycle after their strobes; condMet/linkAddr are combinational.
// Backpressure: none; strobe timing is owned by the controller.
module pc_flags_unit
    import pc_flags_unit_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DISP_W   = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pcEn,
    input  logic                 pcWriteCond,
    input  logic [1:0]           pcSrc,
    input  logic [WIDTH-1:0]     target,
    input  logic [DISP_W-1:0]    disp,
    input  logic [3:0]           cond,
    input  logic                 flagsWrite,
    input  logic [NUM_FLAGS-1:0] flagsMask,
    input  logic [NUM_FLAGS-1:0] aluFlags,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     linkAddr,
    output logic                 condMet,
    output logic [NUM_FLAGS-1:0] flags
);

    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     pc_inc, pc_rel, pc_mux, disp_sext;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic                 cond_met;

    // Evaluated on registered flags only, so a same-edge flag write cannot steer its own branch.
    pc_flags_unit_cond_eval u_cond_eval (
        .flags    (flags_q),
        .cond     (cond),
        .cond_met (cond_met)
    );

    always_comb begin
        pc_inc    = pc_q + WIDTH'(1);
        disp_sext = {{(WIDTH-DISP_W){disp[DISP_W-1]}}, disp};
        pc_rel    = pc_q + disp_sext;

        pc_mux = pc_q;
        case (pc_src_e'(pcSrc))
            PC_INC:  pc_mux = pc_inc;
            PC_ABS:  pc_mux = target;
            PC_REL:  pc_mux = pc_rel;
            PC_HOLD: pc_mux = pc_q;
            default: pc_mux = pc_q;
        endcase

        // A failed conditional branch still advances to the next instruction.
        pc_d = pc_q;
        if (pcEn) begin
            pc_d = pc_mux;
        end else if (pcWriteCond) begin
            pc_d = cond_met ? pc_mux : pc_inc;
        end

        flags_d = flags_q;
        if (flagsWrite) begin
            flags_d = (flags_q & ~flagsMask) | (aluFlags & flagsMask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign pc       = pc_q;
    assign linkAddr = pc_inc;
    assign condMet  = cond_met;
    assign flags    = flags_q;

endmodule

// File: tb/tb_pc_flags_unit.sv
// Randomized and directed bench for pc_flags_unit against a behavioural reference model.
module tb_pc_flags_unit;

    logic        clk;
    logic        reset;
    logic        pcEn;
    logic        pcWriteCond;
    logic [1:0]  pcSrc;
    logic [15:0] target;
    logic [7:0]  disp;
    logic [3:0]  cond;
    logic        flagsWrite;
    logic [4:0]  flagsMask;
    logic [4:0]  aluFlags;
    logic [15:0] pc;
    logic [15:0] linkAddr;
    logic        condMet;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    int          m_pc;
    logic [4:0]  m_flags;

    pc_flags_unit #(
        .WIDTH    (16),
        .DISP_W   (8),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcEn        (pcEn),
        .pcWriteCond (pcWriteCond),
        .pcSrc       (pcSrc),
        .target      (target),
        .disp        (disp),
        .cond        (cond),
        .flagsWrite  (flagsWrite),
        .flagsMask   (flagsMask),
        .aluFlags    (aluFlags),
        .pc          (pc),
        .linkAddr    (linkAddr),
        .condMet     (condMet),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Condition truth table from the flag meanings {C,L,F,Z,N}.
    function automatic bit ref_cond(input logic [3:0] c, input logic [4:0] f);
        bit carry, higher, ovf, equal, greater;
        carry   = f[4];
        higher  = f[3];
        ovf     = f[2];
        equal   = f[1];
        greater = f[0];
        case (c)
            4'd0:    return equal;
            4'd1:    return !equal;
            4'd2:    return carry;
            4'd3:    return !carry;
            4'd4:    return higher;
            4'd5:    return !higher;
            4'd6:    return greater;
            4'd7:    return !greater;
            4'd8:    return ovf;
            4'd9:    return !ovf;
            4'd10:   return !higher && !equal;
            4'd11:   return higher || equal;
            4'd12:   return !greater && !equal;
            4'd13:   return greater || equal;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic cyc(input bit chk_comb);
        int         nxt_pc;
        int         sel_pc;
        logic [4:0] nxt_flags;
        bit         met;
        @(negedge clk);
        met = ref_cond(cond, m_flags);
        if (chk_comb) begin
            check("linkAddr", linkAddr, (m_pc + 1) % 65536);
            check("condMet", condMet, met);
        end
        case (pcSrc)
            2'd0:    sel_pc = (m_pc + 1) % 65536;
            2'd1:    sel_pc = target;
            2'd2:    sel_pc = (m_pc + int'($signed(disp)) + 65536) % 65536;
            default: sel_pc = m_pc;
        endcase
        if (reset)            nxt_pc = 0;
        else if (pcEn)        nxt_pc = sel_pc;
        else if (pcWriteCond) nxt_pc = met ? sel_pc : (m_pc + 1) % 65536;
        else                  nxt_pc = m_pc;
        nxt_flags = m_flags;
        if (reset)           nxt_flags = 5'b0;
        else if (flagsWrite) begin
            for (int i = 0; i < 5; i++) begin
                if (flagsMask[i]) nxt_flags[i] = aluFlags[i];
            end
        end
        @(posedge clk);
        #1;
        m_pc    = nxt_pc;
        m_flags = nxt_flags;
        check("pc", pc, m_pc);
        check("flags", flags, m_flags);
    endtask

    task automatic idle_inputs();
        reset = 0; pcEn = 0; pcWriteCond = 0; pcSrc = 2'd3; target = 0; disp = 0;
        cond = 4'hF; flagsWrite = 0; flagsMask = 0; aluFlags = 0;
    endtask

    initial begin
        m_pc = 0;
        m_flags = 0;
        idle_inputs();
        reset = 1;
        cyc(0);
        check("reset_pc", pc, 16'h0000);
        check("reset_flags", flags, 5'b0);

        // Sequential fetch
        idle_inputs();
        pcEn = 1; pcSrc = 2'd0;
        repeat (3) cyc(1);
        check("inc3", pc, 16'h0003);

        // Taken EQ branch with negative displacement
        idle_inputs();
        pcEn = 1; pcSrc = 2'd1; target = 16'h0010;
        flagsWrite = 1; flagsMask = 5'b11111; aluFlags = 5'b00010;
        cyc(1);
        idle_inputs();
        pcWriteCond = 1; pcSrc = 2'd2; disp = 8'hFC; cond = 4'h0;
        cyc(1);
        check("beq_taken", pc, 16'h000C);

        // Untaken NE branch falls through
        idle_inputs();
        pcEn = 1; pcSrc = 2'd1; target = 16'h0010;
        cyc(1);
        idle_inputs();
        pcWriteCond = 1; pcSrc = 2'd2; disp = 8'hFC; cond = 4'h1;
        #1 check("bne_condmet", condMet, 1'b0);
        cyc(1);
        check("bne_fall", pc, 16'h0011);

        // Absolute jump and wrap cases
        idle_inputs();
        pcEn = 1; pcSrc = 2'd1; target = 16'hBEEF;
        cyc(1);
        check("jump_abs", pc, 16'hBEEF);
        target = 16'hFFFF;
        cyc(1);
        pcSrc = 2'd0;
        cyc(1);
        check("wrap_inc", pc, 16'h0000);
        pcSrc = 2'd1; target = 16'h0002;
        cyc(1);
        pcSrc = 2'd2; disp = 8'h80;
        cyc(1);
        check("wrap_rel", pc, 16'hFF82);

        // Masked flag write and constant conditions
        idle_inputs();
        flagsWrite = 1; flagsMask = 5'b11111; aluFlags = 5'b11111;
        cyc(1);
        flagsMask = 5'b00011; aluFlags = 5'b00000;
        cyc(1);
        check("masked_flags", flags, 5'b11100);
        idle_inputs();
        cond = 4'hE;
        #1 check("cond_uc", condMet, 1'b1);
        cond = 4'hF;
        #1 check("cond_never", condMet, 1'b0);

        // Reset wins over a taken branch
        idle_inputs();
        pcWriteCond = 1; pcSrc = 2'd1; target = 16'h1234; cond = 4'h2; reset = 1;
        cyc(1);
        check("midbranch_pc", pc, 16'h0000);
        check("midbranch_flags", flags, 5'b0);

        // Same-edge flag write does not affect the branch decision
        idle_inputs();
        flagsWrite = 1; flagsMask = 5'b11111; aluFlags = 5'b00010;
        pcWriteCond = 1; pcSrc = 2'd1; target = 16'h4000; cond = 4'h0;
        cyc(1);
        check("oldflags_pc", pc, 16'h0001);
        check("oldflags_flags", flags, 5'b00010);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 40) == 0);
            pcEn        = $urandom_range(0, 3) == 0;
            pcWriteCond = $urandom_range(0, 1);
            pcSrc       = 2'($urandom_range(0, 3));
            target      = 16'($urandom);
            disp        = 8'($urandom);
            cond        = 4'($urandom_range(0, 15));
            flagsWrite  = $urandom_range(0, 1);
            flagsMask   = 5'($urandom);
            aluFlags    = 5'($urandom);
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
